uart_time_reporter: RTL and testbench

//   Transmit-side counterpart of the UART command path. On a request, captures the

---
 rtl/uart_time_reporter_if.sv | 24 ++
 rtl/uart_time_reporter.sv | 167 ++++++++++++++++
 tb/tb_uart_time_reporter.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_time_reporter_if.sv
// Handshake bundle between the time source, the reporter and the uart_tx serialiser.
// The reporter uses the slave modport; whoever drives requests and time uses master.
interface uart_time_reporter_if;
    logic       req;
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
    logic [6:0] msec;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       busy;
    logic       done;

    modport master (
        output req, hour, min, sec, msec, tx_busy,
        input  tx_start, tx_data, busy, done
    );

    modport slave (
        input  req, hour, min, sec, msec, tx_busy,
        output tx_start, tx_data, busy, done
    );
endinterface

// File: rtl/uart_time_reporter.sv
// Captures the current time on request and streams it to uart_tx as "HH:MM:SS.CC".
// Define UART_REPORT_CRLF_EN to append CR LF, which makes the frame 13 bytes.
module uart_time_reporter #(
    parameter logic [7:0] SEP_CHAR      = 8'h3A,
    parameter logic [7:0] DOT_CHAR      = 8'h2E,
    parameter int         BUSY_WAIT_MAX = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    uart_time_reporter_if.slave        bus
);

`ifdef UART_REPORT_CRLF_EN
    localparam logic [3:0] LAST_IDX = 4'd12;
`else
    localparam logic [3:0] LAST_IDX = 4'd10;
`endif

    localparam logic [7:0] WAIT_LAST = 8'(BUSY_WAIT_MAX - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ISSUE     = 3'd1;
    localparam logic [2:0] S_WAIT_ACK  = 3'd2;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;
    localparam logic [2:0] S_FINISH    = 3'd4;

    logic [2:0] state_q,    state_d;
    logic [3:0] idx_q,      idx_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic [4:0] hour_q,     hour_d;
    logic [5:0] min_q,      min_d;
    logic [5:0] sec_q,      sec_d;
    logic [6:0] msec_q,     msec_d;
    logic       tx_start_q, tx_start_d;
    logic [7:0] tx_data_q,  tx_data_d;
    logic       busy_q,     busy_d;
    logic       done_q,     done_d;

    logic [6:0] cs_clamped;
    logic [7:0] frame_byte;

    function automatic logic [7:0] tens_ascii(input logic [6:0] v);
        return 8'h30 + {1'b0, v / 7'd10};
    endfunction

    function automatic logic [7:0] units_ascii(input logic [6:0] v);
        return 8'h30 + {1'b0, v % 7'd10};
    endfunction

    assign cs_clamped = (msec_q > 7'd99) ? 7'd99 : msec_q;

    always_comb begin
        frame_byte = 8'h00;
        case (idx_q)
            4'd0:    frame_byte = tens_ascii({2'b00, hour_q});
            4'd1:    frame_byte = units_ascii({2'b00, hour_q});
            4'd2:    frame_byte = SEP_CHAR;
            4'd3:    frame_byte = tens_ascii({1'b0, min_q});
            4'd4:    frame_byte = units_ascii({1'b0, min_q});
            4'd5:    frame_byte = SEP_CHAR;
            4'd6:    frame_byte = tens_ascii({1'b0, sec_q});
            4'd7:    frame_byte = units_ascii({1'b0, sec_q});
            4'd8:    frame_byte = DOT_CHAR;
            4'd9:    frame_byte = tens_ascii(cs_clamped);
            4'd10:   frame_byte = units_ascii(cs_clamped);
`ifdef UART_REPORT_CRLF_EN
            4'd11:   frame_byte = 8'h0D;
            4'd12:   frame_byte = 8'h0A;
`endif
            default: frame_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        wait_cnt_d = wait_cnt_q;
        hour_d     = hour_q;
        min_d      = min_q;
        sec_d      = sec_q;
        msec_d     = msec_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    hour_d     = bus.hour;
                    min_d      = bus.min;
                    sec_d      = bus.sec;
                    msec_d     = bus.msec;
                    busy_d     = 1'b1;
                    idx_d      = 4'd0;
                    wait_cnt_d = 8'd0;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                tx_start_d = 1'b1;
                tx_data_d  = frame_byte;
                wait_cnt_d = 8'd0;
                state_d    = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                // A serialiser that never raises busy must not hang the frame.
                if (bus.tx_busy || wait_cnt_q == WAIT_LAST) begin
                    wait_cnt_d = 8'd0;
                    state_d    = S_WAIT_DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            S_WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_FINISH;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                idx_d   = 4'd0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            idx_q      <= 4'd0;
            wait_cnt_q <= 8'd0;
            hour_q     <= 5'd0;
            min_q      <= 6'd0;
            sec_q      <= 6'd0;
            msec_q     <= 7'd0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            wait_cnt_q <= wait_cnt_d;
            hour_q     <= hour_d;
            min_q      <= min_d;
            sec_q      <= sec_d;
            msec_q     <= msec_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.tx_start = tx_start_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_uart_time_reporter.sv
// Directed bench for uart_time_reporter: a simple uart_tx busy model, a byte
// monitor, and a linear sequence of frame scenarios checked with immediate assertions.
module tb_uart_time_reporter;

`ifdef UART_REPORT_CRLF_EN
    localparam int FRAME_LEN = 13;
`else
    localparam int FRAME_LEN = 11;
`endif
    localparam int WAIT_MAX = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_time_reporter_if bus();

    uart_time_reporter #(
        .SEP_CHAR      (8'h3A),
        .DOT_CHAR      (8'h2E),
        .BUSY_WAIT_MAX (WAIT_MAX)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // uart_tx stand-in: busy rises one clock after tx_start and stays up 20 clocks
    logic tx_model_en = 1'b1;
    int   busy_cnt    = 0;
    always @(posedge clk) begin
        if (rst)
            busy_cnt <= 0;
        else if (bus.tx_start && tx_model_en)
            busy_cnt <= 20;
        else if (busy_cnt != 0)
            busy_cnt <= busy_cnt - 1;
    end
    assign bus.tx_busy = (busy_cnt != 0);

    logic [7:0] log_q[$];
    int         start_cyc_q[$];
    int         done_cnt    = 0;
    int         consec_err  = 0;
    int         cyc         = 0;
    logic       prev_start  = 1'b0;

    always @(negedge clk) begin
        if (bus.tx_start) begin
            log_q.push_back(bus.tx_data);
            start_cyc_q.push_back(cyc);
            if (prev_start) consec_err++;
            $display("[TB] t=%0t byte %0d = %02h", $time, log_q.size() - 1, bus.tx_data);
        end
        if (bus.done) begin
            done_cnt++;
            $display("[TB] t=%0t done pulse", $time);
        end
        prev_start = bus.tx_start;
        cyc++;
    end

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_frame [13];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic clear_log();
        log_q.delete();
        start_cyc_q.delete();
        done_cnt   = 0;
        consec_err = 0;
    endtask

    task automatic set_time(input logic [4:0] h, input logic [5:0] m,
                            input logic [5:0] s, input logic [6:0] c);
        bus.hour = h;
        bus.min  = m;
        bus.sec  = s;
        bus.msec = c;
    endtask

    task automatic pulse_req();
        @(negedge clk);
        bus.req = 1'b1;
        @(negedge clk);
        bus.req = 1'b0;
        #1;
    endtask

    task automatic wait_bytes(input int count, input int budget, input string tag);
        int n = 0;
        while (log_q.size() < count && n < budget) begin
            tick(1);
            n++;
        end
        chk({tag, "_reached"}, 32'(log_q.size() >= count), 32'd1);
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            tick(1);
            n++;
        end
        chk({tag, "_done_seen"}, 32'(done_cnt != 0), 32'd1);
        chk({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic check_frame(input string tag);
        chk({tag, "_len"}, 32'(log_q.size()), 32'(FRAME_LEN));
        for (int i = 0; i < FRAME_LEN; i++) begin
            logic [7:0] got;
            got = (i < log_q.size()) ? log_q[i] : 8'hxx;
            chk($sformatf("%s_b%0d", tag, i), 32'(got), 32'(exp_frame[i]));
        end
        chk({tag, "_done_once"}, 32'(done_cnt), 32'd1);
        chk({tag, "_no_b2b_start"}, 32'(consec_err), 32'd0);
    endtask

    initial begin
        bus.req = 1'b0;
        set_time(5'd0, 6'd0, 6'd0, 7'd0);

        // reset state
        tick(3);
        chk("rst_tx_start", 32'(bus.tx_start), 32'd0);
        chk("rst_tx_data",  32'(bus.tx_data),  32'h00);
        chk("rst_busy",     32'(bus.busy),     32'd0);
        chk("rst_done",     32'(bus.done),     32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick(2);

        // 1: 13:05:59.07
        exp_frame = '{8'h31, 8'h33, 8'h3A, 8'h30, 8'h35, 8'h3A,
                      8'h35, 8'h39, 8'h2E, 8'h30, 8'h37, 8'h0D, 8'h0A};
        clear_log();
        set_time(5'd13, 6'd5, 6'd59, 7'd7);
        pulse_req();
        chk("t1_busy_after_req", 32'(bus.busy), 32'd1);
        wait_done(2000, "t1");
        tick(5);
        check_frame("t1");

        // 2: second req mid-frame is ignored
        clear_log();
        pulse_req();
        wait_bytes(3, 500, "t2_b3");
        pulse_req();
        wait_done(2000, "t2");
        tick(100);
        check_frame("t2");

        // 3: inputs change after byte 1, snapshot must win
        clear_log();
        set_time(5'd13, 6'd5, 6'd59, 7'd7);
        pulse_req();
        wait_bytes(2, 500, "t3_b1");
        set_time(5'd14, 6'd5, 6'd0, 7'd7);
        wait_done(2000, "t3");
        tick(5);
        check_frame("t3");

        // 4: serialiser never acknowledges, timeout drives every byte
        tx_model_en = 1'b0;
        clear_log();
        set_time(5'd13, 6'd5, 6'd59, 7'd7);
        pulse_req();
        wait_done(2000, "t4");
        tick(5);
        check_frame("t4");
        for (int i = 1; i < FRAME_LEN && i < start_cyc_q.size(); i++) begin
            int gap;
            gap = start_cyc_q[i] - start_cyc_q[i-1];
            chk($sformatf("t4_gap%0d_in_range", i),
                32'(gap >= WAIT_MAX + 1 && gap <= WAIT_MAX + 2), 32'd1);
        end
        tx_model_en = 1'b1;
        tick(3);

        // 5: async reset while byte 4 is being issued
        clear_log();
        pulse_req();
        wait_bytes(5, 500, "t5_b4");
        chk("t5_start_high_pre_rst", 32'(bus.tx_start), 32'd1);
        rst = 1'b1;
        #1;
        chk("t5_rst_tx_start", 32'(bus.tx_start), 32'd0);
        chk("t5_rst_busy",     32'(bus.busy),     32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick(2);
        clear_log();
        pulse_req();
        wait_done(2000, "t5");
        tick(5);
        check_frame("t5");

        // 6: all zero with centiseconds clamped from 120
        exp_frame = '{8'h30, 8'h30, 8'h3A, 8'h30, 8'h30, 8'h3A,
                      8'h30, 8'h30, 8'h2E, 8'h39, 8'h39, 8'h0D, 8'h0A};
        clear_log();
        set_time(5'd0, 6'd0, 6'd0, 7'd120);
        pulse_req();
        wait_done(2000, "t6");
        tick(5);
        check_frame("t6");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
